// File: rtl/audio_pkg.sv
// Shared audio datapath definitions: sample width, saturation limits,
// the saturating adder used by the mixer stages, and the echo FSM states.
package audio_pkg;

  localparam int DATA_W = 24;

  localparam logic signed [DATA_W-1:0] SAMPLE_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] SAMPLE_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [2:0] {
    CLEAR,
    IDLE,
    READ,
    CALC,
    WRITE
  } echo_state_t;

  // One guard bit catches overflow; the guard bit's sign picks the rail.
  function automatic logic signed [DATA_W-1:0] sat_add(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    logic [DATA_W:0] sum;
    sum = {a[DATA_W-1], a} + {b[DATA_W-1], b};
    if (sum[DATA_W] != sum[DATA_W-1]) begin
      sat_add = sum[DATA_W] ? SAMPLE_MIN : SAMPLE_MAX;
    end else begin
      sat_add = sum[DATA_W-1:0];
    end
  endfunction

endpackage

// File: rtl/audio_echo_ram.sv
// Simple dual-port delay buffer with registered read; no array reset so it
// maps onto block RAM.
module echo_ram #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // rd_en holds the tap steady while the FSM works on it.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/audio_echo.sv
// Feedback echo stage: mixes a decayed, delayed copy of its own output into
// the incoming sample and saturates the result for the CODEC write port.
module audio_echo #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in,
  input  logic              in_valid,
  input  logic              enable,
  input  logic [ADDR_W-1:0] delay,
  input  logic [1:0]        decay,
  output logic [DATA_W-1:0] out,
  output logic              out_valid,
  output logic              busy
);
  import audio_pkg::*;

  echo_state_t              state;
  echo_state_t              state_nxt;
  logic [ADDR_W-1:0]        wr_ptr;
  logic signed [DATA_W-1:0] in_lat;
  logic                     en_lat;
  logic [1:0]               decay_lat;
  logic [DATA_W-1:0]        tap;
  logic signed [DATA_W-1:0] tap_scaled;
  logic signed [DATA_W-1:0] mix;
  logic [2:0]               shamt;
  logic                     ram_we;
  logic                     ram_rd_en;
  logic [ADDR_W-1:0]        rd_addr;
  logic [DATA_W-1:0]        ram_wr_data;

  // delay=0 lands on wr_ptr itself, i.e. the oldest sample in the buffer.
  assign rd_addr     = wr_ptr - delay;
  assign ram_rd_en   = (state == IDLE) && in_valid;
  assign ram_we      = (state == CLEAR) || (state == WRITE);
  assign ram_wr_data = (state == CLEAR) ? '0 : out;
  assign shamt       = {1'b0, decay_lat} + 3'd1;
  assign tap_scaled  = $signed(tap) >>> shamt;
  assign mix         = sat_add(in_lat, tap_scaled);
  assign busy        = (state == CLEAR);

  echo_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .we      (ram_we),
    .wr_addr (wr_ptr),
    .wr_data (ram_wr_data),
    .rd_en   (ram_rd_en),
    .rd_addr (rd_addr),
    .rd_data (tap)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR:   if (wr_ptr == {ADDR_W{1'b1}}) state_nxt = IDLE;
      IDLE:    if (in_valid) state_nxt = READ;
      READ:    state_nxt = CALC;
      CALC:    state_nxt = WRITE;
      WRITE:   state_nxt = IDLE;
      default: state_nxt = CLEAR;
    endcase
  end

  // wr_ptr doubles as the clear address, so it is back at 0 when CLEAR ends.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= CLEAR;
      wr_ptr    <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      in_lat    <= '0;
      en_lat    <= 1'b0;
      decay_lat <= '0;
    end else begin
      state     <= state_nxt;
      out_valid <= 1'b0;
      case (state)
        CLEAR: wr_ptr <= wr_ptr + 1'b1;
        IDLE: begin
          if (in_valid) begin
            in_lat    <= in;
            en_lat    <= enable;
            decay_lat <= decay;
          end
        end
        CALC: begin
          out       <= en_lat ? mix : in_lat;
          out_valid <= 1'b1;
        end
        WRITE: wr_ptr <= wr_ptr + 1'b1;
        default: ;
      endcase
    end
  end

endmodule
